// File: rtl/adc_req_scheduler.sv
// adc_req_scheduler
// Shares one ADS7822 12-bit serial ADC between NREQ requesters. Requests are
// arbitrated, CS/DCLK are generated from the 50 MHz clock, the 12-bit result
// is shifted in MSB-first, and it is returned with a one-cycle DONE strobe.
// Optional build macro: ADC_SCHED_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest index wins, no round-robin pointer
//   undefined -> round-robin arbitration starting from requester 0
// DIV must be at least 2.
module adc_req_scheduler #(
    parameter int NREQ    = 4,
    parameter int DIV     = 25,
    parameter int CS_HIGH = 2
) (
    input  logic            i_clk50,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic [NREQ-1:0] o_done,
    output logic [11:0]     o_data,
    output logic            o_busy,
    input  logic            i_din,
    output logic            o_dclk,
    output logic            o_cs
);

    localparam int IDW = $clog2(NREQ);
    localparam int IW1 = IDW + 1;
    localparam int DVW = $clog2(DIV);
    localparam int RCW = $clog2(2 * CS_HIGH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        SHIFT,
        RECOVER
    } state_t;

    state_t          r_state;
    logic [DVW-1:0]  r_div;
    logic            r_dclk;
    logic            r_cs;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic [11:0]     r_data;
    logic            r_busy;
    logic [11:0]     r_shift;
    logic [3:0]      r_rise;
    logic [RCW-1:0]  r_recTick;
    logic [IDW-1:0]  r_id;

    logic            w_tick;
    logic            w_anyReq;
    logic [IDW-1:0]  w_winner;

    assign w_tick   = (r_div == DVW'(DIV - 1));
    assign w_anyReq = |i_req;

`ifdef ADC_SCHED_FIXED_PRIO_EN
    // Fixed priority: scan from the top so the lowest requesting index wins
    always_comb begin
        w_winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) w_winner = IDW'(i);
        end
    end
`else
    logic [IDW-1:0] r_ptr;
    logic [IW1-1:0] w_idx;

    // Round-robin: scan far-to-near after the pointer so the nearest requester wins
    always_comb begin
        w_winner = '0;
        w_idx    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            w_idx = {1'b0, r_ptr} + IW1'(i);
            if (w_idx >= IW1'(NREQ)) w_idx = w_idx - IW1'(NREQ);
            if (i_req[w_idx[IDW-1:0]]) w_winner = w_idx[IDW-1:0];
        end
    end

    // Pointer moves to the winner at each grant so it has lowest priority next time
    always_ff @(posedge i_clk50 or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= IDW'(NREQ - 1);
        end else if (r_state == IDLE && w_anyReq) begin
            r_ptr <= w_winner;
        end
    end
`endif

    // Conversion sequencer: grant, DCLK generation, shift-in, result delivery, CS recovery
    always_ff @(posedge i_clk50 or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_dclk    <= 1'b0;
            r_cs      <= 1'b1;
            r_gnt     <= '0;
            r_done    <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_shift   <= '0;
            r_rise    <= '0;
            r_recTick <= '0;
            r_id      <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    r_dclk <= 1'b0;
                    r_cs   <= 1'b1;
                    r_div  <= '0;
                    if (w_anyReq) begin
                        r_gnt   <= NREQ'(1) << w_winner;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_id    <= w_winner;
                        r_rise  <= '0;
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (w_tick) begin
                        r_div  <= '0;
                        r_dclk <= ~r_dclk;
                        if (!r_dclk) begin
                            r_rise <= r_rise + 4'd1;
                            if (r_rise == 4'd2) r_state <= SHIFT;
                        end
                    end else begin
                        r_div <= r_div + DVW'(1);
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_div <= '0;
                        if (!r_dclk) begin
                            r_dclk  <= 1'b1;
                            r_rise  <= r_rise + 4'd1;
                            r_shift <= {r_shift[10:0], i_din};
                        end else if (r_rise == 4'd15) begin
                            r_dclk    <= 1'b0;
                            r_cs      <= 1'b1;
                            r_data    <= r_shift;
                            r_done    <= NREQ'(1) << r_id;
                            // Pre-advance by one so the first IDLE cycle completes the CS-high window
                            r_div     <= DVW'(1);
                            r_recTick <= '0;
                            r_state   <= RECOVER;
                        end else begin
                            r_dclk <= 1'b0;
                        end
                    end else begin
                        r_div <= r_div + DVW'(1);
                    end
                end
                RECOVER: begin
                    r_dclk <= 1'b0;
                    r_cs   <= 1'b1;
                    if (w_tick) begin
                        r_div <= '0;
                        if (r_recTick == RCW'(2 * CS_HIGH - 1)) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_recTick <= r_recTick + RCW'(1);
                        end
                    end else begin
                        r_div <= r_div + DVW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_gnt  = r_gnt;
    assign o_done = r_done;
    assign o_data = r_data;
    assign o_busy = r_busy;
    assign o_dclk = r_dclk;
    assign o_cs   = r_cs;

endmodule
